// File: rtl/bus_master_port_if.sv
// Host request/response channel plus the serial slave bus lines of the bus master port.
// The master modport is the port's own view; the slave modport is the host and slave side.
interface bus_master_port_if #(
  parameter int N   = 8,
  parameter int ADN = 12
);
  logic           req_valid;
  logic           req_ready;
  logic           req_wren;
  logic [ADN-1:0] req_addr;
  logic [N-1:0]   req_wdata;
  logic           resp_valid;
  logic [N-1:0]   resp_rdata;
  logic           resp_err;
  logic           m_valid;
  logic           m_wren;
  logic           m_addr;
  logic           m_data;
  logic           s_valid;
  logic           s_data;

  modport master (
    input  req_valid, req_wren, req_addr, req_wdata, s_valid, s_data,
    output req_ready, resp_valid, resp_rdata, resp_err, m_valid, m_wren, m_addr, m_data
  );

  modport slave (
    output req_valid, req_wren, req_addr, req_wdata, s_valid, s_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, m_valid, m_wren, m_addr, m_data
  );
endinterface

// File: rtl/bus_master_port.sv
// Serial bus master: takes one parallel host request, shifts it MSB-first onto the slave bus
// and, for reads, deserialises the returned word into a single-cycle response.
module bus_master_port #(
  parameter int N       = 8,
  parameter int ADN     = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  bus_master_port_if.master bus
);

  localparam int CW = $clog2(ADN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LastAddrBit  = CW'(ADN - 1);
  localparam logic [CW-1:0] FirstDataBit = CW'(ADN - N);
  localparam logic [CW-1:0] LastDataBit  = CW'(N - 1);
  localparam logic [CW-1:0] LastGapCycle = CW'(1);
  localparam logic [TW-1:0] LastIdle     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    Idle,
    Hdr,
    Addr,
    Wgap,
    Rwait,
    Rdata,
    Done
  } stateT;

  stateT          state, stateNext;
  logic [CW-1:0]  bitCnt, bitCntNext;
  logic [TW-1:0]  idleCnt, idleCntNext;
  logic [ADN-1:0] addrSh, addrShNext;
  logic [N-1:0]   dataSh, dataShNext;
  logic [N-1:0]   rdSh, rdShNext;
  logic           wrenQ, wrenNext;
  logic [CW-1:0]  nextBit;

  logic           readyQ, readyNext;
  logic           respValidQ, respValidNext;
  logic           respErrQ, respErrNext;
  logic [N-1:0]   respDataQ, respDataNext;
  logic           mValidQ, mValidNext;
  logic           mWrenQ, mWrenNext;
  logic           mAddrQ, mAddrNext;
  logic           mDataQ, mDataNext;

  // State plus every output are registered together, so the bus sees the value for a state
  // during the cycle the FSM sits in it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= Idle;
      bitCnt     <= '0;
      idleCnt    <= '0;
      addrSh     <= '0;
      dataSh     <= '0;
      rdSh       <= '0;
      wrenQ      <= 1'b0;
      readyQ     <= 1'b0;
      respValidQ <= 1'b0;
      respErrQ   <= 1'b0;
      respDataQ  <= '0;
      mValidQ    <= 1'b0;
      mWrenQ     <= 1'b0;
      mAddrQ     <= 1'b0;
      mDataQ     <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      idleCnt    <= idleCntNext;
      addrSh     <= addrShNext;
      dataSh     <= dataShNext;
      rdSh       <= rdShNext;
      wrenQ      <= wrenNext;
      readyQ     <= readyNext;
      respValidQ <= respValidNext;
      respErrQ   <= respErrNext;
      respDataQ  <= respDataNext;
      mValidQ    <= mValidNext;
      mWrenQ     <= mWrenNext;
      mAddrQ     <= mAddrNext;
      mDataQ     <= mDataNext;
    end
  end

  // Next-state and next-output decode; the bus lines idle at 0 unless a state drives them.
  always_comb begin
    stateNext     = state;
    bitCntNext    = bitCnt;
    idleCntNext   = idleCnt;
    addrShNext    = addrSh;
    dataShNext    = dataSh;
    rdShNext      = rdSh;
    wrenNext      = wrenQ;
    readyNext     = readyQ;
    respValidNext = 1'b0;
    respErrNext   = 1'b0;
    respDataNext  = respDataQ;
    mValidNext    = 1'b0;
    mWrenNext     = 1'b0;
    mAddrNext     = 1'b0;
    mDataNext     = 1'b0;
    nextBit       = '0;

    unique case (state)
      Idle: begin
        readyNext = 1'b1;
        if (bus.req_valid && readyQ) begin
          addrShNext = bus.req_addr;
          dataShNext = bus.req_wdata;
          wrenNext   = bus.req_wren;
          readyNext  = 1'b0;
          mValidNext = 1'b1;
          mWrenNext  = bus.req_wren;
          stateNext  = Hdr;
        end
      end

      Hdr, Addr: begin
        if (state == Addr && bitCnt == LastAddrBit) begin
          bitCntNext  = '0;
          idleCntNext = '0;
          mWrenNext   = wrenQ;
          stateNext   = wrenQ ? Wgap : Rwait;
        end else begin
          nextBit    = (state == Hdr) ? '0 : bitCnt + 1'b1;
          bitCntNext = nextBit;
          mValidNext = 1'b1;
          mWrenNext  = wrenQ;
          mAddrNext  = addrSh[ADN-1];
          addrShNext = addrSh << 1;
          // Write data rides on the last N address cycles.
          if (wrenQ && nextBit >= FirstDataBit) begin
            mDataNext  = dataSh[N-1];
            dataShNext = dataSh << 1;
          end
          stateNext = Addr;
        end
      end

      Wgap: begin
        if (bitCnt == LastGapCycle) begin
          respValidNext = 1'b1;
          stateNext     = Done;
        end else begin
          mWrenNext  = wrenQ;
          bitCntNext = bitCnt + 1'b1;
        end
      end

      Rwait, Rdata: begin
        if (bus.s_valid) begin
          idleCntNext = '0;
          if (state == Rwait) begin
            bitCntNext = '0;
            stateNext  = Rdata;
          end else begin
            rdShNext = {rdSh[N-2:0], bus.s_data};
            if (bitCnt == LastDataBit) begin
              respValidNext = 1'b1;
              respDataNext  = {rdSh[N-2:0], bus.s_data};
              stateNext     = Done;
            end else begin
              bitCntNext = bitCnt + 1'b1;
            end
          end
        end else if (idleCnt == LastIdle) begin
          respValidNext = 1'b1;
          respErrNext   = 1'b1;
          respDataNext  = '0;
          stateNext     = Done;
        end else begin
          idleCntNext = idleCnt + 1'b1;
        end
      end

      Done: begin
        readyNext = 1'b1;
        stateNext = Idle;
      end

      default: begin
        stateNext = Idle;
      end
    endcase
  end

  assign bus.req_ready  = readyQ;
  assign bus.resp_valid = respValidQ;
  assign bus.resp_err   = respErrQ;
  assign bus.resp_rdata = respDataQ;
  assign bus.m_valid    = mValidQ;
  assign bus.m_wren     = mWrenQ;
  assign bus.m_addr     = mAddrQ;
  assign bus.m_data     = mDataQ;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: plays host and slave, predicting bus bits, response timing and
// read data from the transfer rules rather than from the design's state machine.
module tb_bus_master_port;

  localparam int N         = 8;
  localparam int ADN       = 12;
  localparam int TIMEOUT   = 64;
  localparam int MaxCycles = 600;

  logic clk = 1'b0;
  logic rstn;

  bus_master_port_if #(.N(N), .ADN(ADN)) bus ();

  bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] refMem   [int];
  logic [N-1:0] slaveMem [int];
  logic [N-1:0] lastRdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request from a negedge and returns after the posedge that takes it.
  task automatic issueRequest(input logic wren, input logic [ADN-1:0] addr, input logic [N-1:0] wdata,
                              output int waits);
    bus.req_valid = 1'b1;
    bus.req_wren  = wren;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waits = 0;
    while (bus.req_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
  endtask

  // One full transaction; for reads wdata is the word the slave returns unless useMem is set.
  task automatic applyStimulus(input logic wren, input logic [ADN-1:0] addr, input logic [N-1:0] wdata,
                               input bit useMem, input int dummyDelay, input int gapAt, input int gapLen,
                               input bit holdNext, input bit expectNoWait);
    int waits;
    int respCycle;
    int lateValid;
    int expResp;
    int zeros;
    int got;
    int idx;
    bit v;
    bit expErr;
    bit pv[$];
    bit pd[$];
    logic [ADN:0]   validSeq;
    logic [ADN:0]   wrenSeq;
    logic [ADN:0]   dataSeq;
    logic [ADN-1:0] addrSeen;
    logic [ADN-1:0] expDataBits;
    logic           hdrAddr;
    logic           respErrSeen;
    logic [N-1:0]   respDataSeen;
    logic [N-1:0]   expData;
    logic [N-1:0]   acc;
    logic [N-1:0]   word;

    validSeq = '0; wrenSeq = '0; dataSeq = '0; addrSeen = '0; hdrAddr = 1'b0;
    respCycle = -1; lateValid = 0; respErrSeen = 1'b0; respDataSeen = '0;
    expErr = 1'b0; expData = lastRdata; expResp = ADN + 4; word = wdata;

    issueRequest(wren, addr, wdata, waits);
    if (expectNoWait) checkOutput("b2bAcceptWait", waits, 0);
    else checkOutput("acceptTimeout", waits >= 200, 0);

    for (int c = 1; c <= MaxCycles && respCycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("readyDuringTxn", bus.req_ready, 0);
        if (holdNext) bus.req_wren = 1'b0;
        else bus.req_valid = 1'b0;
      end
      if (c <= ADN + 1) begin
        validSeq = {validSeq[ADN-1:0], bus.m_valid};
        wrenSeq  = {wrenSeq[ADN-1:0], bus.m_wren};
        dataSeq  = {dataSeq[ADN-1:0], bus.m_data};
        if (c >= 2) addrSeen = {addrSeen[ADN-2:0], bus.m_addr};
        else hdrAddr = bus.m_addr;
      end else if (bus.m_valid !== 1'b0) begin
        lateValid++;
      end
      if (bus.resp_valid === 1'b1) begin
        respCycle    = c;
        respErrSeen  = bus.resp_err;
        respDataSeen = bus.resp_rdata;
      end

      // Once the address is known the slave schedule and its expected outcome are fixed.
      if (c == ADN + 1 && !wren) begin
        if (useMem) word = slaveMem.exists(int'(addrSeen)) ? slaveMem[int'(addrSeen)] : '0;
        for (int i = 0; i < dummyDelay; i++) begin pv.push_back(1'b0); pd.push_back(1'b0); end
        pv.push_back(1'b1); pd.push_back(1'b1);
        for (int j = 0; j < N; j++) begin
          if (j == gapAt)
            for (int g = 0; g < gapLen; g++) begin pv.push_back(1'b0); pd.push_back(1'b0); end
          pv.push_back(1'b1); pd.push_back(word[N-1-j]);
        end
        expResp = -1; zeros = 0; got = -1; acc = '0;
        for (int i = 0; expResp < 0 && i < pv.size() + TIMEOUT + 1; i++) begin
          v = (i < pv.size()) ? pv[i] : 1'b0;
          if (v) begin
            zeros = 0;
            if (got < 0) got = 0;
            else begin
              acc = {acc[N-2:0], pd[i]};
              got++;
              if (got == N) begin expResp = ADN + 3 + i; expErr = 1'b0; expData = acc; end
            end
          end else begin
            zeros++;
            if (zeros == TIMEOUT) begin expResp = ADN + 3 + i; expErr = 1'b1; expData = '0; end
          end
        end
      end

      if (c <= ADN + 1 || wren) begin
        bus.s_valid = 1'($urandom);
        bus.s_data  = 1'($urandom);
      end else begin
        idx = c - (ADN + 2);
        bus.s_valid = (idx < pv.size()) ? pv[idx] : 1'b0;
        bus.s_data  = (idx < pd.size()) ? pd[idx] : 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 1'b0;

    expDataBits = wren ? ADN'(wdata) : '0;
    checkOutput("respSeen", respCycle >= 0, 1);
    checkOutput("mValidSeq", validSeq, {(ADN+1){1'b1}});
    checkOutput("mWrenSeq", wrenSeq, wren ? {(ADN+1){1'b1}} : '0);
    checkOutput("hdrBits", {hdrAddr, dataSeq[ADN]}, 0);
    checkOutput("mAddrBits", addrSeen, addr);
    checkOutput("mDataBits", dataSeq[ADN-1:0], expDataBits);
    checkOutput("mValidAfterAddr", lateValid, 0);
    checkOutput("respCycle", respCycle, expResp);
    checkOutput("respErr", respErrSeen, expErr);
    checkOutput("respRdata", respDataSeen, expData);
    if (useMem && !wren && !expErr)
      checkOutput("readBack", respDataSeen, refMem.exists(int'(addr)) ? refMem[int'(addr)] : '0);

    @(negedge clk);
    checkOutput("respStrobeWidth", bus.resp_valid, 0);
    checkOutput("readyAfterResp", bus.req_ready, 1);

    if (wren) begin
      refMem[int'(addr)] = wdata;
      slaveMem[int'(addrSeen)] = dataSeq[N-1:0];
    end else begin
      lastRdata = expData;
    end
  endtask

  // Pulls reset in the middle of a write's address phase.
  task automatic resetMidOp();
    int waits;
    int strays;
    strays = 0;
    issueRequest(1'b1, 12'h3C3, 8'h5A, waits);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1 checkOutput("abortMValid", bus.m_valid, 0);
    checkOutput("abortReady", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lastRdata = '0;
    #1 checkOutput("abortRdata", bus.resp_rdata, 0);
    @(negedge clk);
    checkOutput("abortReadyBack", bus.req_ready, 1);
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid !== 1'b0 || bus.m_valid !== 1'b0) strays++;
      @(negedge clk);
    end
    checkOutput("abortNoResp", strays, 0);
  endtask

  initial begin
    logic [ADN-1:0] pool [4];
    logic           rw;
    int             sel;
    int             dd;

    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wren  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 1'b0;
    lastRdata     = '0;

    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
                                 bus.m_valid, bus.m_wren, bus.m_addr, bus.m_data}, 0);
    rstn = 1'b1;
    #1 checkOutput("readyBeforeEdge", bus.req_ready, 0);
    @(negedge clk);
    checkOutput("readyAfterRelease", bus.req_ready, 1);

    applyStimulus(1'b1, 12'h0A5, 8'h3C, 1'b0, 0, -1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'hFFF, 8'hA7, 1'b0, 2, -1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h0A5, 8'h81, 1'b0, 2, 4, 3, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h123, 8'h55, 1'b0, TIMEOUT + 10, -1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h456, 8'hC3, 1'b0, TIMEOUT - 1, -1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h789, 8'h6E, 1'b0, 0, 5, TIMEOUT - 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h789, 8'h6E, 1'b0, 0, 5, TIMEOUT, 1'b0, 1'b0);

    resetMidOp();

    applyStimulus(1'b1, 12'h2D4, 8'h96, 1'b0, 0, -1, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 12'h2D4, 8'h00, 1'b1, 1, -1, 0, 1'b0, 1'b1);

    for (int k = 0; k < 4; k++) pool[k] = ADN'($urandom);
    for (int t = 0; t < 30; t++) begin
      rw  = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      dd  = (sel == 0) ? TIMEOUT - 1 : (sel == 1) ? TIMEOUT + 3 : int'($urandom_range(0, 5));
      applyStimulus(rw, pool[$urandom_range(0, 3)], N'($urandom), 1'b1, dd,
                    int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
